// File: rtl/xillybus_mem_pkg.sv
// Shared constants and pointer arithmetic for the Xillybus seekable-memory endpoint.
package xillybus_mem_pkg;

    localparam int unsigned RELOAD_CYCLES = 1;

    // Advance a pointer; at the last address either wrap to zero or hold.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                            input logic [31:0] last,
                                            input logic        wrap_en);
        if (ptr == last) begin
            return wrap_en ? '0 : last;
        end
        return ptr + 32'd1;
    endfunction

endpackage

// File: rtl/xillybus_sdp_ram.sv
// Simple dual-port RAM: host write + host read, plus a read-only user port.
// Both read ports are registered and return the pre-write word on a collision.
module xillybus_sdp_ram
    import xillybus_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic [ADDR_W-1:0] i_usr_addr,
    output logic [DATA_W-1:0] o_usr_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_usr_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Only the output registers are reset; array contents stay undefined.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rd_data  <= '0;
            r_usr_data <= '0;
        end else begin
            if (i_rd_en) begin
                r_rd_data <= r_mem[i_rd_addr];
            end
            r_usr_data <= r_mem[i_usr_addr];
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_usr_data = r_usr_data;

endmodule

// File: rtl/xillybus_mem_port.sv
// Seekable memory endpoint for Xillybus user_{r,w}_mem_* streams with
// independent read/write pointers, auto-increment and optional EOF at the end.
module xillybus_mem_port
    import xillybus_mem_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 5,
    parameter bit          EOF_AT_END = 1'b0
) (
    input  logic              bus_clk,
    input  logic              bus_rstn,
    input  logic              user_w_mem_wren,
    input  logic [DATA_W-1:0] user_w_mem_data,
    output logic              user_w_mem_full,
    input  logic              user_w_mem_open,
    input  logic              user_r_mem_rden,
    output logic [DATA_W-1:0] user_r_mem_data,
    output logic              user_r_mem_empty,
    output logic              user_r_mem_eof,
    input  logic              user_r_mem_open,
    input  logic [ADDR_W-1:0] user_mem_addr,
    input  logic              user_mem_addr_update,
    input  logic [ADDR_W-1:0] usr_addr,
    output logic [DATA_W-1:0] usr_rdata
);

    localparam logic [31:0] LAST = 32'((64'd1 << ADDR_W) - 64'd1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [3:0]        r_reload_cnt;
    logic              r_eof;

    logic              w_reload;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_rd_last;
    logic [ADDR_W-1:0] w_wr_next;
    logic [ADDR_W-1:0] w_rd_next;

    // Flags follow the open signals combinationally, masked while reloading.
    assign w_reload         = (r_reload_cnt != '0);
    assign user_w_mem_full  = w_reload | ~user_w_mem_open;
    assign user_r_mem_empty = w_reload | ~user_r_mem_open | r_eof;
    assign user_r_mem_eof   = r_eof;

    assign w_wr_en   = bus_rstn & user_w_mem_wren & ~user_w_mem_full;
    assign w_rd_en   = bus_rstn & user_r_mem_rden & ~user_r_mem_empty;
    assign w_rd_last = (r_rd_ptr == '1);
    assign w_wr_next = ADDR_W'(ptr_inc(32'(r_wr_ptr), LAST, 1'b1));
    assign w_rd_next = ADDR_W'(ptr_inc(32'(r_rd_ptr), LAST, !EOF_AT_END));

    // A seek coinciding with an access lets the access use the old pointer.
    always_ff @(posedge bus_clk) begin
        if (!bus_rstn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_reload_cnt <= 4'(RELOAD_CYCLES);
            r_eof        <= 1'b0;
        end else if (user_mem_addr_update) begin
            r_wr_ptr     <= user_mem_addr;
            r_rd_ptr     <= user_mem_addr;
            r_reload_cnt <= 4'(RELOAD_CYCLES);
            r_eof        <= 1'b0;
        end else begin
            if (w_reload) begin
                r_reload_cnt <= r_reload_cnt - 4'd1;
            end
            if (w_wr_en) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_rd_en) begin
                r_rd_ptr <= w_rd_next;
                if (EOF_AT_END && w_rd_last) begin
                    r_eof <= 1'b1;
                end
            end
        end
    end

    xillybus_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk      (bus_clk),
        .i_rstn     (bus_rstn),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_data  (user_w_mem_data),
        .i_rd_en    (w_rd_en),
        .i_rd_addr  (r_rd_ptr),
        .o_rd_data  (user_r_mem_data),
        .i_usr_addr (usr_addr),
        .o_usr_data (usr_rdata)
    );

endmodule

// File: tb/tb_xillybus_mem_port.sv
// Bench for xillybus_mem_port: an 8-bit wrapping instance (A) and a 32-bit EOF instance (B).
module tb_xillybus_mem_port;

    typedef struct {
        logic        sel;
        logic        seek;
        logic [4:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic        rd;
        logic        chk;
        logic [31:0] rdexp;
        logic [4:0]  ua;
        logic        chku;
        logic [31:0] uexp;
        logic        full;
        logic        empty;
        logic        eof;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn, wopen, ropen, wren, rden, seek, sel;
    logic [31:0] wdata;
    logic [4:0]  addr, uaddr;

    logic        a_full, a_empty, a_eof, b_full, b_empty, b_eof;
    logic [7:0]  a_data, a_udata;
    logic [31:0] b_data, b_udata;

    logic        o_full, o_empty, o_eof;
    logic [31:0] o_data, o_udata;

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[$];

    always #5 clk = ~clk;

    xillybus_mem_port #(.DATA_W(8), .ADDR_W(5), .EOF_AT_END(1'b0)) u_a (
        .bus_clk(clk), .bus_rstn(rstn),
        .user_w_mem_wren(wren & ~sel), .user_w_mem_data(wdata[7:0]),
        .user_w_mem_full(a_full), .user_w_mem_open(wopen),
        .user_r_mem_rden(rden & ~sel), .user_r_mem_data(a_data),
        .user_r_mem_empty(a_empty), .user_r_mem_eof(a_eof), .user_r_mem_open(ropen),
        .user_mem_addr(addr), .user_mem_addr_update(seek & ~sel),
        .usr_addr(uaddr), .usr_rdata(a_udata)
    );

    xillybus_mem_port #(.DATA_W(32), .ADDR_W(5), .EOF_AT_END(1'b1)) u_b (
        .bus_clk(clk), .bus_rstn(rstn),
        .user_w_mem_wren(wren & sel), .user_w_mem_data(wdata),
        .user_w_mem_full(b_full), .user_w_mem_open(wopen),
        .user_r_mem_rden(rden & sel), .user_r_mem_data(b_data),
        .user_r_mem_empty(b_empty), .user_r_mem_eof(b_eof), .user_r_mem_open(ropen),
        .user_mem_addr(addr), .user_mem_addr_update(seek & sel),
        .usr_addr(uaddr), .usr_rdata(b_udata)
    );

    assign o_full  = sel ? b_full  : a_full;
    assign o_empty = sel ? b_empty : a_empty;
    assign o_eof   = sel ? b_eof   : a_eof;
    assign o_data  = sel ? b_data  : {24'd0, a_data};
    assign o_udata = sel ? b_udata : {24'd0, a_udata};

    function automatic vec_t mk(input logic s, input logic sk_, input logic [4:0] a,
                                input logic w, input logic [31:0] d, input logic r,
                                input logic c, input logic [31:0] x, input logic [4:0] u,
                                input logic cu, input logic [31:0] ux,
                                input logic f, input logic e, input logic eo);
        vec_t v;
        v.sel = s; v.seek = sk_; v.addr = a; v.wr = w; v.wd = d; v.rd = r;
        v.chk = c; v.rdexp = x; v.ua = u; v.chku = cu; v.uexp = ux;
        v.full = f; v.empty = e; v.eof = eo;
        return v;
    endfunction

    function automatic vec_t sk(input logic s, input logic [4:0] a);
        return mk(s, 1, a, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    endfunction
    function automatic vec_t id(input logic s);
        return mk(s, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t wr(input logic s, input logic [31:0] d);
        return mk(s, 0, 0, 1, d, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t rd(input logic s, input logic [31:0] x);
        return mk(s, 0, 0, 0, 0, 1, 1, x, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [31:0] e;
        sel = v.sel; seek = v.seek; addr = v.addr; wren = v.wr; wdata = v.wd;
        rden = v.rd; uaddr = v.ua;
        if (v.chk) exp_q.push_back(v.rdexp);
        step();
        if (v.chk) begin
            e = exp_q.pop_front();
            chk({tag, ".data"}, o_data, e);
        end
        if (v.chku) chk({tag, ".usr"}, o_udata, v.uexp);
        chk({tag, ".full"},  32'(o_full),  32'(v.full));
        chk({tag, ".empty"}, 32'(o_empty), 32'(v.empty));
        chk({tag, ".eof"},   32'(o_eof),   32'(v.eof));
    endtask

    initial begin
        // Instance A: seek/write/read, wrap at 31, seek colliding with a write.
        vecs.push_back(sk(0, 3));  vecs.push_back(id(0));
        vecs.push_back(wr(0, 'hA5)); vecs.push_back(wr(0, 'h5A));
        vecs.push_back(sk(0, 3));  vecs.push_back(id(0));
        vecs.push_back(rd(0, 'hA5)); vecs.push_back(rd(0, 'h5A));
        vecs.push_back(sk(0, 31)); vecs.push_back(id(0));
        vecs.push_back(wr(0, 'h11)); vecs.push_back(wr(0, 'h22));
        vecs.push_back(sk(0, 31)); vecs.push_back(id(0));
        vecs.push_back(rd(0, 'h11)); vecs.push_back(rd(0, 'h22));
        vecs.push_back(sk(0, 4));  vecs.push_back(id(0));
        vecs.push_back(mk(0, 1, 9, 1, 'h77, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(wr(0, 'h88)); vecs.push_back(wr(0, 'h99));
        vecs.push_back(sk(0, 4));  vecs.push_back(id(0)); vecs.push_back(rd(0, 'h77));
        vecs.push_back(sk(0, 9));  vecs.push_back(id(0)); vecs.push_back(rd(0, 'h99));
        // Instance B: EOF at end, then read-first collisions on both ports.
        vecs.push_back(sk(1, 30)); vecs.push_back(id(1));
        vecs.push_back(wr(1, 'h30303030)); vecs.push_back(wr(1, 'h31313131));
        vecs.push_back(sk(1, 30)); vecs.push_back(id(1));
        vecs.push_back(rd(1, 'h30303030));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 'h31313131, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 'h31313131, 0, 0, 0, 0, 1, 1));
        vecs.push_back(sk(1, 0));  vecs.push_back(id(1));
        vecs.push_back(sk(1, 7));  vecs.push_back(id(1)); vecs.push_back(wr(1, 'h12345678));
        vecs.push_back(sk(1, 7));  vecs.push_back(id(1));
        vecs.push_back(mk(1, 0, 0, 1, 'hDEADBEEF, 1, 1, 'h12345678, 0, 0, 0, 0, 0, 0));
        vecs.push_back(sk(1, 7));  vecs.push_back(id(1)); vecs.push_back(rd(1, 'hDEADBEEF));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 'hDEADBEEF, 0, 0, 0));
        vecs.push_back(sk(1, 7));  vecs.push_back(id(1));
        vecs.push_back(mk(1, 0, 0, 1, 'hCAFEF00D, 0, 0, 0, 7, 1, 'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 'hCAFEF00D, 0, 0, 0));

        rstn = 1'b0; wopen = 1'b1; ropen = 1'b1; wren = 1'b1; rden = 1'b1;
        seek = 1'b0; sel = 1'b0; wdata = 32'h0; addr = '0; uaddr = '0;
        step(); step();
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            chk($sformatf("rst%0d.full", s),  32'(o_full),  32'd1);
            chk($sformatf("rst%0d.empty", s), 32'(o_empty), 32'd1);
            chk($sformatf("rst%0d.eof", s),   32'(o_eof),   32'd0);
            chk($sformatf("rst%0d.data", s),  o_data,       32'd0);
        end
        rstn = 1'b1; wren = 1'b0; rden = 1'b0; sel = 1'b0;
        step();
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            chk($sformatf("rel%0d.full", s),  32'(o_full),  32'd0);
            chk($sformatf("rel%0d.empty", s), 32'(o_empty), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // Closing a file forces the flag but leaves pointers where they were.
        apply(sk(0, 12), "oc.seek"); apply(id(0), "oc.idle"); apply(wr(0, 'h44), "oc.w44");
        wopen = 1'b0; #1;
        chk("oc.closed_full", 32'(o_full), 32'd1);
        apply(mk(0, 0, 0, 1, 'h55, 0, 0, 0, 0, 0, 0, 1, 0, 0), "oc.w55");
        ropen = 1'b0; #1;
        chk("oc.closed_empty", 32'(o_empty), 32'd1);
        wopen = 1'b1; ropen = 1'b1; #1;
        chk("oc.reopen_full", 32'(o_full), 32'd0);
        apply(wr(0, 'h66), "oc.w66");
        apply(sk(0, 12), "oc.seek2"); apply(id(0), "oc.idle2");
        apply(rd(0, 'h44), "oc.r44"); apply(rd(0, 'h66), "oc.r66");

        // Reset coinciding with a read discards the read and zeroes the pointers.
        apply(sk(0, 3), "mr.seek"); apply(id(0), "mr.idle");
        rstn = 1'b0; rden = 1'b1;
        step();
        chk("mr.data",  o_data,        32'd0);
        chk("mr.full",  32'(o_full),   32'd1);
        chk("mr.empty", 32'(o_empty),  32'd1);
        rstn = 1'b1; rden = 1'b0;
        step();
        chk("mr.rel_empty", 32'(o_empty), 32'd0);
        apply(rd(0, 'h22), "mr.r0");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
